// File: rtl/sroc_seq_pkg.sv
// Shared definitions for the SROC acquisition sequencer: state encoding and default widths.
package sroc_seq_pkg;

   localparam int DECIM_WIDTH_DEF = 8;
   localparam int COUNT_WIDTH_DEF = 16;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_SYNC = 3'd1,
      S_WAIT_PPS  = 3'd2,
      S_RUN       = 3'd3,
      S_DONE      = 3'd4
   } seq_state_e;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_WAIT_SYNC = 3'd1;
   localparam logic [2:0] ST_WAIT_PPS  = 3'd2;
   localparam logic [2:0] ST_RUN       = 3'd3;
   localparam logic [2:0] ST_DONE      = 3'd4;

endpackage

// File: rtl/sroc_decimator.sv
// SROC strobe decimator: fires on a strobe when the down-counter sits at zero, then reloads.
module sroc_decimator #(
   parameter int DECIM_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   strobe,
   input  logic [DECIM_WIDTH-1:0] reload,
   output logic                   fire
);

   logic [DECIM_WIDTH-1:0] r_cnt;

   assign fire = strobe & (r_cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (strobe) begin
         if (r_cnt == '0) begin
            r_cnt <= reload;
         end else begin
            r_cnt <= r_cnt - DECIM_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/sroc_acq_sequencer.sv
// Acquisition sequencer: arms on request, waits for SROC sync (and optionally PPS),
// then issues decimated acquisition triggers until the programmed count is reached.
module sroc_acq_sequencer
   import sroc_seq_pkg::*;
#(
   parameter int DECIM_WIDTH = DECIM_WIDTH_DEF,
   parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
   input  logic                   evrClk,
   input  logic                   evrReset,
   input  logic                   evrSROCstrobe,
   input  logic                   evrSROCsynced,
   input  logic                   evrPulsePerSecondMarker,
   input  logic                   arm,
   input  logic                   abort,
   input  logic [DECIM_WIDTH-1:0] cfgDecimation,
   input  logic [COUNT_WIDTH-1:0] cfgCount,
   input  logic                   cfgStartOnPPS,
   output logic                   acqTrigger,
   output logic                   busy,
   output logic                   done,
   output logic                   syncLost,
   output logic [COUNT_WIDTH-1:0] tickIndex,
   output logic [2:0]             state
);

   logic [2:0]             r_state;
   logic                   r_acqTrigger;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_syncLost;
   logic                   r_ppsDly;
   logic                   r_startOnPps;
   logic [DECIM_WIDTH-1:0] r_decim;
   logic [COUNT_WIDTH-1:0] r_count;
   logic [COUNT_WIDTH-1:0] r_tick;

   logic                   w_ppsRise;
   logic                   w_decClear;
   logic                   w_decStrobe;
   logic                   w_fire;
   logic                   w_lastTick;
   logic [DECIM_WIDTH-1:0] w_reload;
   logic [COUNT_WIDTH-1:0] w_tickNext;

   // A decimation of 0 behaves like 1, so both reload to 0 (trigger on every strobe).
   function automatic logic [DECIM_WIDTH-1:0] decim_reload(input logic [DECIM_WIDTH-1:0] dec);
      return (dec == '0) ? '0 : dec - DECIM_WIDTH'(1);
   endfunction

   assign w_ppsRise   = evrPulsePerSecondMarker & ~r_ppsDly;
   assign w_reload    = decim_reload(r_decim);
   assign w_decClear  = (r_state != ST_RUN);
   assign w_decStrobe = (r_state == ST_RUN) & evrSROCstrobe & evrSROCsynced & ~abort;
   assign w_tickNext  = r_tick + COUNT_WIDTH'(1);
   assign w_lastTick  = (r_count != '0) && (w_tickNext == r_count);

   sroc_decimator #(
      .DECIM_WIDTH(DECIM_WIDTH)
   ) u_decim (
      .clk    (evrClk),
      .rst    (evrReset),
      .clear  (w_decClear),
      .strobe (w_decStrobe),
      .reload (w_reload),
      .fire   (w_fire)
   );

   always_ff @(posedge evrClk or posedge evrReset) begin
      if (evrReset) begin
         r_state      <= ST_IDLE;
         r_acqTrigger <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_syncLost   <= 1'b0;
         r_ppsDly     <= 1'b0;
         r_startOnPps <= 1'b0;
         r_decim      <= '0;
         r_count      <= '0;
         r_tick       <= '0;
      end else begin
         r_ppsDly     <= evrPulsePerSecondMarker;
         r_acqTrigger <= 1'b0;
         r_done       <= 1'b0;
         if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (arm) begin
                     r_decim      <= cfgDecimation;
                     r_count      <= cfgCount;
                     r_startOnPps <= cfgStartOnPPS;
                     r_tick       <= '0;
                     r_syncLost   <= 1'b0;
                     r_state      <= ST_WAIT_SYNC;
                     r_busy       <= 1'b1;
                  end
               end
               ST_WAIT_SYNC: begin
                  if (evrSROCsynced) begin
                     r_state <= r_startOnPps ? ST_WAIT_PPS : ST_RUN;
                  end
               end
               ST_WAIT_PPS: begin
                  if (!evrSROCsynced) begin
                     r_syncLost <= 1'b1;
                     r_state    <= ST_IDLE;
                     r_busy     <= 1'b0;
                  end else if (w_ppsRise) begin
                     r_state <= ST_RUN;
                  end
               end
               ST_RUN: begin
                  // Losing sync pre-empts any strobe arriving in the same cycle.
                  if (!evrSROCsynced) begin
                     r_syncLost <= 1'b1;
                     r_state    <= ST_IDLE;
                     r_busy     <= 1'b0;
                  end else if (w_fire) begin
                     r_acqTrigger <= 1'b1;
                     r_tick       <= w_tickNext;
                     if (w_lastTick) begin
                        r_state <= ST_DONE;
                     end
                  end
               end
               ST_DONE: begin
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign acqTrigger = r_acqTrigger;
   assign busy       = r_busy;
   assign done       = r_done;
   assign syncLost   = r_syncLost;
   assign tickIndex  = r_tick;
   assign state      = r_state;

endmodule

// File: tb/tb_sroc_acq_sequencer.sv
// Self-checking bench for sroc_acq_sequencer: vector table, scenario sequences and
// randomized traffic compared against a behavioural model.
module tb_sroc_acq_sequencer;

   localparam int DW = 8;
   localparam int CW = 16;
   localparam int P_IDLE  = 0;
   localparam int P_WSYNC = 1;
   localparam int P_WPPS  = 2;
   localparam int P_RUN   = 3;
   localparam int P_DONE  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          strobe, synced, pps, arm, abort, cfgPps;
   logic [DW-1:0] cfgDec;
   logic [CW-1:0] cfgCnt;
   logic          acqTrigger, busy, done, syncLost;
   logic [CW-1:0] tickIndex;
   logic [2:0]    state;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   int m_phase, m_dec_eff, m_cnt, m_tick, m_n;
   bit m_pps_on, m_sl, m_trig, m_done, m_pps_prev;

   typedef struct {
      logic          arm, abort, strobe, synced, pps;
      logic [DW-1:0] dec;
      logic [CW-1:0] cnt;
      logic          ppsOn;
      logic          trig, dn, bsy, sl;
      logic [CW-1:0] tick;
      logic [2:0]    st;
   } vec_t;

   vec_t tbl[18];

   always #5 clk = ~clk;

   sroc_acq_sequencer #(
      .DECIM_WIDTH(DW),
      .COUNT_WIDTH(CW)
   ) dut (
      .evrClk                  (clk),
      .evrReset                (rst),
      .evrSROCstrobe           (strobe),
      .evrSROCsynced           (synced),
      .evrPulsePerSecondMarker (pps),
      .arm                     (arm),
      .abort                   (abort),
      .cfgDecimation           (cfgDec),
      .cfgCount                (cfgCnt),
      .cfgStartOnPPS           (cfgPps),
      .acqTrigger              (acqTrigger),
      .busy                    (busy),
      .done                    (done),
      .syncLost                (syncLost),
      .tickIndex               (tickIndex),
      .state                   (state)
   );

   function automatic vec_t mk(input int a, input int ab, input int s, input int sy, input int p,
                               input int d, input int c, input int po, input int tr, input int dn,
                               input int bs, input int sl, input int tk, input int st);
      vec_t v;
      v.arm = a[0]; v.abort = ab[0]; v.strobe = s[0]; v.synced = sy[0]; v.pps = p[0];
      v.dec = DW'(d); v.cnt = CW'(c); v.ppsOn = po[0];
      v.trig = tr[0]; v.dn = dn[0]; v.bsy = bs[0]; v.sl = sl[0];
      v.tick = CW'(tk); v.st = 3'(st);
      return v;
   endfunction

   function automatic void model_reset();
      m_phase = P_IDLE; m_dec_eff = 1; m_cnt = 0; m_tick = 0; m_n = 0;
      m_pps_on = 0; m_sl = 0; m_trig = 0; m_done = 0; m_pps_prev = 0;
   endfunction

   // One clock edge of the sequencer, described by its run rules rather than its registers.
   function automatic void model_step();
      bit rise;
      m_trig = 0;
      m_done = 0;
      if (rst) begin
         model_reset();
         return;
      end
      rise = pps && !m_pps_prev;
      m_pps_prev = pps;
      if (abort) begin
         m_phase = P_IDLE;
      end else begin
         case (m_phase)
            P_IDLE: if (arm) begin
               m_dec_eff = (cfgDec == 0) ? 1 : int'(cfgDec);
               m_cnt = int'(cfgCnt);
               m_pps_on = cfgPps;
               m_tick = 0;
               m_sl = 0;
               m_phase = P_WSYNC;
            end
            P_WSYNC: if (synced) begin
               m_phase = m_pps_on ? P_WPPS : P_RUN;
               m_n = 0;
            end
            P_WPPS: if (!synced) begin
               m_sl = 1; m_phase = P_IDLE;
            end else if (rise) begin
               m_phase = P_RUN; m_n = 0;
            end
            P_RUN: if (!synced) begin
               m_sl = 1; m_phase = P_IDLE;
            end else if (strobe) begin
               if (m_n % m_dec_eff == 0) begin
                  m_trig = 1;
                  m_tick = (m_tick + 1) % 65536;
                  if (m_cnt != 0 && m_tick == m_cnt) m_phase = P_DONE;
               end
               m_n++;
            end
            P_DONE: begin
               m_done = 1; m_phase = P_IDLE;
            end
            default: m_phase = P_IDLE;
         endcase
      end
   endfunction

   function automatic logic [31:0] dut_vec();
      return {9'd0, acqTrigger, done, busy, syncLost, tickIndex, state};
   endfunction

   function automatic logic [31:0] model_vec();
      logic mb;
      mb = (m_phase != P_IDLE);
      return {9'd0, m_trig, m_done, mb, m_sl, m_tick[15:0], m_phase[2:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick_cycle();
      @(posedge clk);
      #1;
      model_step();
      chk("model", dut_vec(), model_vec());
   endtask

   task automatic do_arm(input int d, input int c, input bit p);
      cfgDec = DW'(d); cfgCnt = CW'(c); cfgPps = p;
      arm = 1'b1;
      tick_cycle();
      arm = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick_cycle();
      abort = 1'b0;
   endtask

   initial begin
      int ntr, sidx, last_c, done_c, first, drop;
      bit wrap, prev_ff;
      int trig_at[3];

      rst = 1'b1; arm = 0; abort = 0; strobe = 0; synced = 0; pps = 0;
      cfgDec = '0; cfgCnt = '0; cfgPps = 0;
      model_reset();
      tick_cycle();
      tick_cycle();
      chk("reset_state", dut_vec(), 32'd0);

      // Arm on the very first edge after reset release
      rst = 1'b0;
      synced = 1'b1;
      do_arm(2, 2, 0);
      chk("first_edge_arm_state", 32'(state), 32'(P_WSYNC));
      do_abort();

      // Table-driven vectors
      tbl[0]  = mk(1,0,0,1,0, 2,2,0, 0,0,1,0,0,1);
      tbl[1]  = mk(0,0,0,1,0, 2,2,0, 0,0,1,0,0,3);
      tbl[2]  = mk(0,0,1,1,0, 2,2,0, 1,0,1,0,1,3);
      tbl[3]  = mk(0,0,1,1,0, 2,2,0, 0,0,1,0,1,3);
      tbl[4]  = mk(0,0,0,1,0, 2,2,0, 0,0,1,0,1,3);
      tbl[5]  = mk(0,0,1,1,0, 2,2,0, 1,0,1,0,2,4);
      tbl[6]  = mk(0,0,0,1,0, 2,2,0, 0,1,0,0,2,0);
      tbl[7]  = mk(0,0,0,1,0, 2,2,0, 0,0,0,0,2,0);
      tbl[8]  = mk(1,0,0,1,0, 1,0,1, 0,0,1,0,0,1);
      tbl[9]  = mk(0,0,0,1,0, 1,0,1, 0,0,1,0,0,2);
      tbl[10] = mk(0,0,0,1,1, 1,0,1, 0,0,1,0,0,3);
      tbl[11] = mk(0,0,1,1,1, 1,0,1, 1,0,1,0,1,3);
      tbl[12] = mk(0,0,1,0,1, 1,0,1, 0,0,0,1,1,0);
      tbl[13] = mk(1,0,0,1,0, 3,1,0, 0,0,1,0,0,1);
      tbl[14] = mk(1,1,0,1,0, 3,1,0, 0,0,0,0,0,0);
      tbl[15] = mk(1,0,0,1,0, 3,1,0, 0,0,1,0,0,1);
      tbl[16] = mk(0,0,0,1,0, 3,1,0, 0,0,1,0,0,3);
      tbl[17] = mk(0,1,1,1,0, 3,1,0, 0,0,0,0,0,0);
      for (int i = 0; i < 18; i++) begin
         arm = tbl[i].arm; abort = tbl[i].abort; strobe = tbl[i].strobe;
         synced = tbl[i].synced; pps = tbl[i].pps;
         cfgDec = tbl[i].dec; cfgCnt = tbl[i].cnt; cfgPps = tbl[i].ppsOn;
         tick_cycle();
         chk($sformatf("tbl[%0d]", i), dut_vec(),
             {9'd0, tbl[i].trig, tbl[i].dn, tbl[i].bsy, tbl[i].sl, tbl[i].tick, tbl[i].st});
      end
      arm = 0; abort = 0; strobe = 0; synced = 1; pps = 0;
      tick_cycle();

      // Decimation 4, count 3, strobe every 10 cycles
      do_arm(4, 3, 0);
      tick_cycle();
      sidx = 0; ntr = 0; last_c = -1; done_c = -1;
      trig_at[0] = 0; trig_at[1] = 0; trig_at[2] = 0;
      for (int c = 0; c < 100; c++) begin
         strobe = (c % 10 == 9);
         tick_cycle();
         if (strobe) sidx++;
         if (acqTrigger) begin
            if (ntr < 3) trig_at[ntr] = sidx;
            ntr++;
            last_c = c;
         end
         if (done) done_c = c;
      end
      strobe = 0;
      chk("dec4_ntrig", ntr, 3);
      chk("dec4_trig0_strobe", trig_at[0], 1);
      chk("dec4_trig1_strobe", trig_at[1], 5);
      chk("dec4_trig2_strobe", trig_at[2], 9);
      chk("dec4_done_latency", done_c, last_c + 1);
      chk("dec4_tickIndex", 32'(tickIndex), 3);

      // Start on PPS with the marker already high at arm
      pps = 1;
      tick_cycle();
      tick_cycle();
      do_arm(1, 0, 1);
      tick_cycle();
      ntr = 0;
      for (int c = 0; c < 30; c++) begin
         strobe = (c % 10 == 9);
         tick_cycle();
         if (acqTrigger) ntr++;
      end
      pps = 0;
      for (int c = 0; c < 200; c++) begin
         strobe = (c % 10 == 9);
         tick_cycle();
         if (acqTrigger) ntr++;
      end
      chk("pps_early_triggers", ntr, 0);
      chk("pps_still_waiting", 32'(state), 32'(P_WPPS));
      strobe = 0; pps = 1;
      tick_cycle();
      chk("pps_rise_to_run", 32'(state), 32'(P_RUN));
      first = -1;
      for (int c = 0; c < 25; c++) begin
         strobe = (c % 10 == 4);
         tick_cycle();
         if (acqTrigger && first < 0) first = c;
      end
      strobe = 0;
      chk("pps_first_trigger", first, 4);
      do_abort();
      pps = 0;

      // Decimation 0, continuous: tickIndex wraps while busy holds
      do_arm(0, 0, 0);
      tick_cycle();
      strobe = 1;
      wrap = 0; prev_ff = 0; drop = 0;
      for (int c = 0; c < 65540; c++) begin
         tick_cycle();
         if (!busy) drop++;
         if (prev_ff && tickIndex == '0) wrap = 1;
         prev_ff = (tickIndex == 16'hFFFF);
      end
      strobe = 0;
      chk("wrap_seen", 32'(wrap), 1);
      chk("wrap_busy_drops", drop, 0);
      do_abort();

      // Sync lost after two triggers
      do_arm(1, 0, 0);
      tick_cycle();
      strobe = 1;
      tick_cycle();
      tick_cycle();
      chk("synclost_two_ticks", 32'(tickIndex), 2);
      synced = 0;
      tick_cycle();
      chk("synclost_flag", 32'(syncLost), 1);
      chk("synclost_state", 32'(state), 32'(P_IDLE));
      chk("synclost_no_trig", 32'(acqTrigger), 0);
      synced = 1; strobe = 0;
      tick_cycle();
      chk("synclost_no_done", 32'(done), 0);
      do_arm(1, 0, 0);
      chk("synclost_cleared_by_arm", 32'(syncLost), 0);
      do_abort();

      // Abort coinciding with arm and a qualifying strobe
      do_arm(1, 0, 0);
      tick_cycle();
      strobe = 1; arm = 1; abort = 1;
      tick_cycle();
      chk("abort_no_trig", 32'(acqTrigger), 0);
      chk("abort_state", 32'(state), 32'(P_IDLE));
      chk("abort_busy", 32'(busy), 0);
      strobe = 0; arm = 0; abort = 0;
      tick_cycle();

      // Asynchronous reset mid-run
      do_arm(1, 0, 0);
      tick_cycle();
      strobe = 1;
      tick_cycle();
      tick_cycle();
      chk("prereset_busy", 32'(busy), 1);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("async_reset_outputs", dut_vec(), 32'd0);
      tick_cycle();
      rst = 1'b0;
      ntr = 0;
      for (int c = 0; c < 6; c++) begin
         tick_cycle();
         if (acqTrigger || done) ntr++;
      end
      strobe = 0;
      chk("post_reset_no_trig", ntr, 0);

      // Randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         arm    = ($urandom_range(0, 19) == 0);
         abort  = ($urandom_range(0, 59) == 0);
         strobe = ($urandom_range(0, 2) == 0);
         synced = ($urandom_range(0, 49) != 0);
         if ($urandom_range(0, 29) == 0) pps = ~pps;
         cfgDec = DW'($urandom_range(0, 4));
         cfgCnt = CW'($urandom_range(0, 6));
         cfgPps = ($urandom_range(0, 3) == 0);
         tick_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sroc_acq_sequencer.md
SROC_ACQ_SEQUENCER -- requirements
Module: sroc_acq_sequencer

Interface
REQ-001 The block SHALL have parameter DECIM_WIDTH, default 8: width of the SROC decimation setting.
REQ-002 The block SHALL have parameter COUNT_WIDTH, default 16: width of the trigger-count setting and of tickIndex.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, declared first: evrClk (in, 1, EVR recovered clock) and evrReset (in, 1).
REQ-004 The block SHALL have input evrSROCstrobe (1): one-cycle pulse per SROC period.
REQ-005 The block SHALL have input evrSROCsynced (1): SROC phase locked to the heartbeat.
REQ-006 The block SHALL have input evrPulsePerSecondMarker (1): PPS level from the EVR.
REQ-007 The block SHALL have inputs arm (1) and abort (1): one-cycle control pulses.
REQ-008 The block SHALL have input cfgDecimation (DECIM_WIDTH): SROC strobes per trigger.
REQ-009 The block SHALL have input cfgCount (COUNT_WIDTH): triggers per run; 0 means continuous.
REQ-010 The block SHALL have input cfgStartOnPPS (1): delay the first trigger until a PPS edge.
REQ-011 The block SHALL have output acqTrigger (1): one-cycle acquisition trigger pulse.
REQ-012 The block SHALL have outputs busy (1) and done (1): busy is high in any non-IDLE state; done is a one-cycle completion pulse.
REQ-013 The block SHALL have output syncLost (1): sticky flag, SROC sync dropped while running.
REQ-014 The block SHALL have outputs tickIndex (COUNT_WIDTH), the number of triggers issued in the current run, and state (3), the encoded FSM state.

Function
REQ-015 The FSM SHALL have exactly these states: IDLE, WAIT_SYNC, WAIT_PPS, RUN, DONE.
REQ-016 An arm pulse in IDLE SHALL do all of the following on the next cycle: latch cfgDecimation, cfgCount and cfgStartOnPPS; clear tickIndex; clear syncLost; enter WAIT_SYNC.
REQ-017 An arm pulse in any state other than IDLE SHALL be ignored.
REQ-018 A latched decimation of 0 SHALL be treated as 1.
REQ-019 WAIT_SYNC SHALL remain until evrSROCsynced=1, then enter WAIT_PPS if the latched cfgStartOnPPS=1, otherwise RUN.
REQ-020 WAIT_PPS SHALL enter RUN on the first rising edge of evrPulsePerSecondMarker, detected against a one-cycle-delayed copy; a level already high on entry SHALL NOT count as an edge.
REQ-021 Entering RUN SHALL zero the decimation counter, so the first evrSROCstrobe in RUN issues a trigger.
REQ-022 In RUN, on each evrSROCstrobe: if the counter is 0, acqTrigger SHALL be asserted on the next cycle, the counter reloaded with decimation-1, and tickIndex incremented; otherwise the counter SHALL decrement.
REQ-023 When a trigger brings tickIndex to a non-zero latched cfgCount, the FSM SHALL enter DONE together with that trigger.
REQ-024 DONE SHALL assert done for exactly one cycle, which is the cycle after the final acqTrigger, and then return to IDLE.
REQ-025 With a latched cfgCount of 0, tickIndex SHALL wrap from all-ones to 0 and the run SHALL continue.
REQ-026 If evrSROCsynced=0 in RUN or WAIT_PPS, the block SHALL set syncLost, issue no trigger that cycle even if a strobe is present, not assert done, and enter IDLE.
REQ-027 An abort pulse SHALL force IDLE on the next cycle from any state, without asserting done or acqTrigger.
REQ-028 When abort and arm coincide, abort SHALL win.
REQ-029 When abort coincides with a trigger-qualifying strobe, no trigger SHALL be issued.
REQ-030 All outputs SHALL be registered.
REQ-031 tickIndex SHALL hold its value in IDLE until the next accepted arm.

Reset
REQ-032 evrReset SHALL asynchronously force state=IDLE, acqTrigger=0, done=0, busy=0, syncLost=0, tickIndex=0, the decimation counter to 0 and all latched configuration to 0.
REQ-033 Reset asserted mid-run SHALL produce no trigger or done pulse.
REQ-034 After reset deassertion, the block SHALL accept an arm on the first clock edge.

Structure
REQ-035 Package sroc_seq_pkg SHALL hold the state enumeration, its 3-bit encoding (IDLE=0, WAIT_SYNC=1, WAIT_PPS=2, RUN=3, DONE=4) and the default widths.
REQ-036 The decimation counter SHALL be a sub-module sroc_decimator with ports clk, rst, clear, strobe, reload value and a fire output; the FSM and the flags SHALL remain in the top level.

Verification
REQ-037 Scenario: cfgDecimation=4, cfgCount=3, PPS off, synced=1, strobe every 10 cycles -> triggers after strobes 1, 5 and 9; done one cycle after the third trigger; tickIndex=3.
REQ-038 Scenario: cfgStartOnPPS=1, PPS held high at arm and rising 200 cycles after falling -> no trigger before the next strobe following that rising edge.
REQ-039 Scenario: cfgDecimation=0, cfgCount=0 -> a trigger on every strobe; tickIndex wraps 0xFFFF->0 with busy staying 1.
REQ-040 Scenario: evrSROCsynced dropped after 2 triggers -> syncLost=1, IDLE, no done; a subsequent arm clears syncLost.
REQ-041 Scenario: abort coincident with both arm and a qualifying strobe -> no trigger, state IDLE, busy=0 next cycle.
REQ-042 Scenario: evrReset pulsed mid-RUN -> all outputs 0 immediately, without waiting for a clock edge; no trigger afterwards until re-armed.
